// File: rtl/wb_ctrl_pkg.sv
// Shared widths, constants and writeback source encoding for the register-file
// write path.
package wb_ctrl_pkg;
  localparam int XLEN    = 32;
  localparam int REG_NUM = 32;
  localparam int AW      = 5;

  localparam logic [AW-1:0]   ZeroReg  = '0;
  localparam logic [XLEN-1:0] ZeroWord = '0;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LSU  = 2'd2
  } wb_src_e;
endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO with occupancy count; pointers wrap modulo DEPTH,
// so DEPTH must be a power of two.
module wb_fifo #(
  parameter  int W     = 37,
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_data,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

  // Storage needs no reset; only the pointers/count define validity.
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= i_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/wb_ctrl.sv
// Writeback controller: arbitrates LSU loads over buffered ALU results onto a
// registered register-file write port and keeps the per-register busy scoreboard.
module wb_ctrl #(
  parameter int XLEN       = wb_ctrl_pkg::XLEN,
  parameter int REG_NUM    = wb_ctrl_pkg::REG_NUM,
  parameter int AW         = wb_ctrl_pkg::AW,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_valid,
  output logic               alu_ready,
  input  logic [AW-1:0]      alu_rd,
  input  logic [XLEN-1:0]    alu_wdata,
  input  logic               lsu_valid,
  output logic               lsu_ready,
  input  logic [AW-1:0]      lsu_rd,
  input  logic [XLEN-1:0]    lsu_wdata,
  input  logic               iss_valid,
  input  logic [AW-1:0]      iss_rd,
  output logic [REG_NUM-1:0] busy_o,
  output logic               rd_we,
  output logic [AW-1:0]      rd_waddr,
  output logic [XLEN-1:0]    rd_wdata
);
  import wb_ctrl_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [REG_NUM-1:0] OneHot0 = REG_NUM'(1);

  logic               w_push, w_pop, w_full, w_empty;
  logic [CW-1:0]      w_count;
  logic [AW+XLEN-1:0] w_head;
  wb_src_e            w_src;
  logic [AW-1:0]      w_rd;
  logic [XLEN-1:0]    w_wd;
  logic [REG_NUM-1:0] w_set, w_clr;

  logic [SW-1:0]      r_starve;
  logic               r_rd_we;
  logic [AW-1:0]      r_rd_waddr;
  logic [XLEN-1:0]    r_rd_wdata;
  logic [REG_NUM-1:0] r_busy;

  wb_fifo #(.W(AW + XLEN), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({alu_rd, alu_wdata}),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Readies are held low while reset is asserted; no same-cycle pop credit.
  assign alu_ready = !rst && (w_count < CW'(FIFO_DEPTH));
  assign lsu_ready = !rst && (r_starve != SW'(STARVE_MAX));
  assign w_push    = alu_valid && alu_ready && !w_full;

  always_comb begin
    w_src = SRC_NONE;
    w_rd  = ZeroReg;
    w_wd  = ZeroWord;
    w_pop = 1'b0;
    if (lsu_valid && lsu_ready) begin
      w_src = SRC_LSU;
      w_rd  = lsu_rd;
      w_wd  = lsu_wdata;
    end else if (!w_empty) begin
      w_src = SRC_ALU;
      w_pop = 1'b1;
      {w_rd, w_wd} = w_head;
    end
  end

  // Counts LSU wins that bypassed a waiting ALU result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_starve <= '0;
    else if (w_pop || w_empty)          r_starve <= '0;
    else if (w_src == SRC_LSU)          r_starve <= r_starve + SW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_we    <= 1'b0;
      r_rd_waddr <= ZeroReg;
      r_rd_wdata <= ZeroWord;
    end else begin
      r_rd_we <= (w_src != SRC_NONE) && (w_rd != ZeroReg);
      if (w_src != SRC_NONE) begin
        r_rd_waddr <= w_rd;
        r_rd_wdata <= w_wd;
      end
    end
  end

  assign w_set = (iss_valid && iss_rd != ZeroReg) ? (OneHot0 << iss_rd) : '0;
  assign w_clr = r_rd_we ? (OneHot0 << r_rd_waddr) : '0;

  // Set is applied after clear so a same-cycle reissue keeps the bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= ((r_busy & ~w_clr) | w_set) & ~OneHot0;
  end

  assign busy_o   = r_busy;
  assign rd_we    = r_rd_we;
  assign rd_waddr = r_rd_waddr;
  assign rd_wdata = r_rd_wdata;
endmodule

// File: tb/tb_wb_ctrl.sv
// Self-checking bench for wb_ctrl: directed scenarios plus random traffic,
// compared each cycle against a queue-based model of the writeback rules.
module tb_wb_ctrl;
  localparam int D  = 2;
  localparam int SM = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic        alu_valid = 0, lsu_valid = 0, iss_valid = 0;
  logic [4:0]  alu_rd = 0, lsu_rd = 0, iss_rd = 0;
  logic [31:0] alu_wdata = 0, lsu_wdata = 0;
  logic        alu_ready, lsu_ready, rd_we;
  logic [4:0]  rd_waddr;
  logic [31:0] rd_wdata, busy_o;

  always #5 clk = ~clk;

  wb_ctrl #(.FIFO_DEPTH(D), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_wdata(alu_wdata),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wdata(lsu_wdata),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_o(busy_o),
    .rd_we(rd_we), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata)
  );

  int checks = 0, failures = 0;

  typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;
  ent_t        aq[$];
  int          starve;
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  logic [71:0] w_act;
  assign w_act = {rd_we, rd_waddr, rd_wdata, busy_o, alu_ready, lsu_ready};

  function automatic logic [71:0] exp_vec();
    logic ar, lr;
    ar = (aq.size() < D);
    lr = (starve < SM);
    return {m_we, m_addr, m_data, m_busy, ar, lr};
  endfunction

  task automatic model_reset();
    aq.delete(); starve = 0; m_busy = '0; m_we = 0; m_addr = '0; m_data = '0;
  endtask

  // One clock of the reference model, then advance the DUT.
  task automatic tick();
    logic ar, lr, ne, win, pop;
    logic [31:0] nb;
    ent_t w;
    ar = (aq.size() < D); lr = (starve < SM); ne = (aq.size() > 0);
    win = 0; pop = 0; w = '{5'd0, 32'd0};
    nb = m_busy;
    if (m_we) nb[m_addr] = 1'b0;
    if (iss_valid && iss_rd != 0) nb[iss_rd] = 1'b1;
    if (lsu_valid && lr) begin win = 1; w = '{lsu_rd, lsu_wdata}; end
    else if (ne) begin win = 1; pop = 1; w = aq.pop_front(); end
    if (alu_valid && ar) aq.push_back('{alu_rd, alu_wdata});
    if (pop || !ne) starve = 0;
    else if (lsu_valid && lr) starve++;
    m_busy = nb;
    m_we = win && (w.rd != 0);
    if (win) begin m_addr = w.rd; m_data = w.d; end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    alu_valid = 0; lsu_valid = 0; iss_valid = 0;
  endtask

  // Issuing to a busy register is illegal unless it is being written back now.
  always @(posedge clk)
    if (!rst && iss_valid && iss_rd != 0 && busy_o[iss_rd] && !(rd_we && rd_waddr == iss_rd)) begin
      failures++;
      $display("FAIL illegal_issue rd=%0d busy=1 required=0", iss_rd);
    end

  task automatic test_reset();
    idle(); alu_valid = 1; lsu_valid = 1;
    @(posedge clk); #1;
    checks++; if (w_act !== 72'h0) begin failures++; $display("FAIL reset_state act=%h exp=%h", w_act, 72'h0); end
    idle(); rst = 0; model_reset(); #1;
    checks++; if (w_act !== 72'h3) begin failures++; $display("FAIL reset_release act=%h exp=%h", w_act, 72'h3); end
    @(posedge clk); #1;
  endtask

  task automatic test_alu_only();
    idle(); iss_valid = 1; iss_rd = 5;
    checks++; if (w_act !== exp_vec()) begin failures++; $display("FAIL alu_only_iss act=%h exp=%h", w_act, exp_vec()); end
    tick(); idle();
    alu_valid = 1; alu_rd = 5; alu_wdata = 32'h1234;
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL alu_only_ready act=%b exp=1", alu_ready); end
    tick(); idle();
    checks++; if (rd_we !== 1'b0) begin failures++; $display("FAIL alu_only_t1 rd_we=%b exp=0", rd_we); end
    tick();
    checks++; if ({rd_we, rd_waddr, rd_wdata, busy_o[5]} !== {1'b1, 5'd5, 32'h1234, 1'b1}) begin
      failures++; $display("FAIL alu_only_t2 we=%b addr=%0d data=%h busy5=%b exp 1/5/1234/1", rd_we, rd_waddr, rd_wdata, busy_o[5]); end
    tick();
    checks++; if (busy_o[5] !== 1'b0 || w_act !== exp_vec()) begin
      failures++; $display("FAIL alu_only_clr act=%h exp=%h", w_act, exp_vec()); end
  endtask

  task automatic test_lsu_priority();
    idle(); iss_valid = 1; iss_rd = 6; tick(); iss_rd = 7; tick(); idle();
    alu_valid = 1; alu_rd = 6; alu_wdata = 32'hA; tick(); idle();
    lsu_valid = 1; lsu_rd = 7; lsu_wdata = 32'hB;
    checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL lsu_prio_ready act=%b exp=1", lsu_ready); end
    tick(); idle();
    checks++; if ({rd_we, rd_waddr, rd_wdata} !== {1'b1, 5'd7, 32'hB}) begin
      failures++; $display("FAIL lsu_prio_first we=%b addr=%0d data=%h exp 1/7/b", rd_we, rd_waddr, rd_wdata); end
    tick();
    checks++; if ({rd_we, rd_waddr, rd_wdata} !== {1'b1, 5'd6, 32'hA}) begin
      failures++; $display("FAIL lsu_prio_second we=%b addr=%0d data=%h exp 1/6/a", rd_we, rd_waddr, rd_wdata); end
    tick();
    checks++; if (w_act !== exp_vec()) begin failures++; $display("FAIL lsu_prio_end act=%h exp=%h", w_act, exp_vec()); end
  endtask

  task automatic test_starvation();
    int nxt = 0;
    logic acc;
    idle(); alu_valid = 1; alu_rd = 10; alu_wdata = 32'h10A; tick(); idle();
    lsu_valid = 1; lsu_rd = 11; lsu_wdata = $urandom;
    for (int k = 0; k < 10; k++) begin
      checks++; if (w_act !== exp_vec()) begin failures++; $display("FAIL starve_cyc%0d act=%h exp=%h", k, w_act, exp_vec()); end
      if (k == 4) begin
        checks++; if (lsu_ready !== 1'b0) begin failures++; $display("FAIL starve_block lsu_ready=%b exp=0", lsu_ready); end
      end
      acc = (starve < SM);
      tick();
      if (k == 4) begin
        checks++; if ({rd_we, rd_waddr, lsu_ready} !== {1'b1, 5'd10, 1'b1}) begin
          failures++; $display("FAIL starve_drain we=%b addr=%0d lsu_ready=%b exp 1/10/1", rd_we, rd_waddr, lsu_ready); end
      end
      if (acc) begin nxt++; lsu_rd = 5'(11 + nxt); lsu_wdata = $urandom; end
    end
    idle(); tick();
  endtask

  task automatic test_fifo_full();
    int ai = 0;
    logic acc;
    logic [4:0] seen[$];
    idle();
    for (int k = 0; k < 20; k++) begin
      lsu_valid = (k < 12); lsu_rd = 5'(24 + k % 6); lsu_wdata = $urandom;
      alu_valid = (ai < 3); alu_rd = 5'(20 + ai); alu_wdata = 32'hF0 + ai;
      checks++; if (w_act !== exp_vec()) begin failures++; $display("FAIL full_cyc%0d act=%h exp=%h", k, w_act, exp_vec()); end
      if (k == 2) begin
        checks++; if (alu_ready !== 1'b0) begin failures++; $display("FAIL full_ready alu_ready=%b exp=0", alu_ready); end
      end
      acc = alu_valid && (aq.size() < D);
      tick();
      if (acc) ai++;
      if (rd_we && rd_waddr >= 20 && rd_waddr <= 22) seen.push_back(rd_waddr);
    end
    checks++;
    if (seen.size() != 3 || seen[0] != 20 || seen[1] != 21 || seen[2] != 22) begin
      failures++; $display("FAIL full_order got %0d alu writes %p exp 20,21,22", seen.size(), seen); end
    idle();
  endtask

  task automatic test_x0_collision();
    idle(); alu_valid = 1; alu_rd = 0; alu_wdata = 32'h55;
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL x0_ready act=%b exp=1", alu_ready); end
    tick(); idle(); tick();
    checks++; if (rd_we !== 1'b0 || alu_ready !== 1'b1 || w_act !== exp_vec()) begin
      failures++; $display("FAIL x0_consume act=%h exp=%h", w_act, exp_vec()); end
    iss_valid = 1; iss_rd = 9; tick(); idle();
    alu_valid = 1; alu_rd = 9; alu_wdata = 32'h99; tick(); idle(); tick();
    checks++; if ({rd_we, rd_waddr, busy_o[9]} !== {1'b1, 5'd9, 1'b1}) begin
      failures++; $display("FAIL collide_pre we=%b addr=%0d busy9=%b exp 1/9/1", rd_we, rd_waddr, busy_o[9]); end
    iss_valid = 1; iss_rd = 9; tick(); idle();
    checks++; if (busy_o[9] !== 1'b1 || w_act !== exp_vec()) begin
      failures++; $display("FAIL collide_set busy9=%b exp=1 act=%h exp=%h", busy_o[9], w_act, exp_vec()); end
  endtask

  task automatic test_random();
    int r;
    for (int k = 0; k < 400; k++) begin
      alu_valid = $urandom_range(0, 1); alu_rd = 5'($urandom_range(0, 31)); alu_wdata = $urandom;
      lsu_valid = ($urandom_range(0, 2) == 0); lsu_rd = 5'($urandom_range(0, 31)); lsu_wdata = $urandom;
      r = $urandom_range(1, 31); iss_rd = 5'(r);
      iss_valid = ($urandom_range(0, 2) == 0) && !(m_busy[r] && !(m_we && m_addr == 5'(r)));
      checks++; if (w_act !== exp_vec()) begin failures++; $display("FAIL random_cyc%0d act=%h exp=%h", k, w_act, exp_vec()); end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    rst = 1; #2; rst = 0; model_reset(); idle();
    @(posedge clk); #1;
    lsu_valid = 1; lsu_rd = 0; lsu_wdata = 32'h1;
    iss_valid = 1; iss_rd = 5; tick();
    iss_rd = 6; alu_valid = 1; alu_rd = 5; alu_wdata = 32'h5; tick();
    iss_valid = 0; alu_rd = 6; alu_wdata = 32'h6; tick();
    idle();
    checks++; if (busy_o !== 32'h60 || alu_ready !== 1'b0 || w_act !== exp_vec()) begin
      failures++; $display("FAIL rstmid_setup busy=%h alu_ready=%b exp 60/0", busy_o, alu_ready); end
    #2; rst = 1; #1;
    checks++; if ({busy_o, rd_we, alu_ready, lsu_ready} !== 35'h0) begin
      failures++; $display("FAIL rstmid_async busy=%h we=%b ar=%b lr=%b exp all 0", busy_o, rd_we, alu_ready, lsu_ready); end
    model_reset();
    @(posedge clk); #1; rst = 0; #1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (rd_we !== 1'b0 || w_act !== exp_vec()) begin
        failures++; $display("FAIL rstmid_after%0d act=%h exp=%h", k, w_act, exp_vec()); end
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_alu_only();
    test_lsu_priority();
    test_starvation();
    test_fifo_full();
    test_x0_collision();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_ctrl.md
Name: wb_ctrl

Overview:
- Writeback controller; it is the producer side of the general-register write port (rd_we / rd_waddr / rd_wdata).
- Merges results from the single-cycle ALU and the multi-cycle LSU onto one registered write port.
- ALU results are buffered in a small FIFO. LSU load data takes priority, subject to an anti-starvation guard.
- Keeps a per-register busy scoreboard that the issue/hazard logic uses to stall dependent instructions.

Parameters:
- XLEN, 32, data width of results and write data.
- REG_NUM, 32, number of architectural registers; also the width of the scoreboard.
- AW, 5, register address width; must equal log2(REG_NUM).
- FIFO_DEPTH, 2, number of ALU result FIFO entries; power of two, at least 2.
- STARVE_MAX, 4, consecutive LSU wins allowed while the FIFO is non-empty before the FIFO is forced to drain.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous reset, active-high.
- alu_valid, in, 1, ALU result valid.
- alu_ready, out, 1, ALU result accepted when alu_valid and alu_ready are both high.
- alu_rd, in, AW, ALU destination register.
- alu_wdata, in, XLEN, ALU result.
- lsu_valid, in, 1, LSU load result valid.
- lsu_ready, out, 1, LSU result accepted when lsu_valid and lsu_ready are both high.
- lsu_rd, in, AW, LSU destination register.
- lsu_wdata, in, XLEN, load data.
- iss_valid, in, 1, an instruction with a destination register issues this cycle.
- iss_rd, in, AW, destination of the issuing instruction.
- busy_o, out, REG_NUM, scoreboard; bit n high means a write to xn is pending.
- rd_we, out, 1, register write enable (registered).
- rd_waddr, out, AW, register write address (registered).
- rd_wdata, out, XLEN, register write data (registered).

Behaviour:
- Reset is asynchronous. On reset:
  - rd_we=0, rd_waddr=0, rd_wdata=0.
  - busy_o=0 and the FIFO is empty.
  - The starvation counter is 0.
  - alu_ready and lsu_ready may only go high once rst is deasserted.
  - A reset mid-operation discards all buffered results and pending busy bits.
- alu_ready = (fifo_count < FIFO_DEPTH). There is no same-cycle pop credit.
- An accepted ALU result is pushed into the FIFO. A push and a pop in the same cycle are legal.
- lsu_ready = !(starve_cnt == STARVE_MAX).
- Each cycle the winner is selected in this order:
  - If lsu_valid and lsu_ready: the LSU wins.
  - Else if the FIFO is non-empty: pop the FIFO head.
  - Else: no write.
- Starvation counter:
  - Increments when the LSU wins while the FIFO is non-empty.
  - Resets to 0 on any FIFO pop or whenever the FIFO is empty.
  - It saturates at STARVE_MAX. In that cycle the FIFO head is forced out and the counter clears.
- Latency: the winner is registered onto rd_* at the next posedge. Handshake to rd_we=1 is exactly 1 cycle for the LSU. For the ALU it is at least 2 cycles (push, then pop).
- rd_we is high for exactly one cycle per winning result.
- A result with rd=0 is still consumed (handshake completes, FIFO pops) but drives rd_we=0.
- Scoreboard:
  - Bit iss_rd is set on iss_valid when iss_rd != 0.
  - Bit rd_waddr is cleared at the posedge where rd_we=1.
  - If set and clear hit the same bit in the same cycle, set wins.
  - Bit 0 is constant 0.
- Issuing to a register whose busy bit is already set is illegal (the issue logic stalls instead); the bench asserts on it.
- The FIFO wraps its pointers modulo FIFO_DEPTH. The count field is log2(FIFO_DEPTH)+1 bits wide.

Decomposition:
- Shared defines: XLEN, AW, REG_NUM, ZeroReg and ZeroWord constants, and a wb_src encoding (NONE/ALU/LSU).
- One sub-module: wb_fifo, a parameterised synchronous FIFO with push/pop/count, full/empty flags and asynchronous reset.
- Scoreboard, arbiter and output registers live in wb_ctrl.

Test Plan:
- ALU only:
  - Stimulus: iss x5, then ALU result rd=5, wdata=0x1234 accepted at cycle t.
  - Required: rd_we=1, waddr=5, wdata=0x1234 at t+2; busy_o[5] 1 to 0 after that edge.
- LSU priority:
  - Stimulus: FIFO holds ALU x6=0xA; at the same cycle, LSU x7=0xB accepted.
  - Required: x7 written first; x6 in the following cycle.
- Starvation:
  - Stimulus: FIFO non-empty; lsu_valid held high with a new rd each cycle.
  - Required: after 4 LSU writes, lsu_ready=0 for one cycle and the FIFO head is written; then the LSU resumes.
- FIFO full:
  - Stimulus: 3 back-to-back ALU results while the LSU occupies the port.
  - Required: alu_ready drops after 2 pushes; no result lost or duplicated; order preserved.
- x0 and set/clear collision:
  - Stimulus: ALU result with rd=0.
  - Required: consumed, with rd_we=0.
  - Stimulus: iss x9 in the same cycle as rd_we for x9.
  - Required: busy_o[9] stays 1.
- Reset mid-operation:
  - Stimulus: FIFO holds 2 entries, busy bits = 0x0000_0060; assert rst asynchronously.
  - Required: busy_o=0, rd_we=0, FIFO empty immediately; no writes after release.
